// File: rtl/regfile_wb_arbiter_if.sv
// Purpose: bundles the writeback requester handshake and register-file write ports.
// Latency: n/a (signal bundle only).
// Backpressure: req_ready from the arbiter holds requesters; no other flow control.
// Ports (via modports):
//   master - drives wb_stall, req_valid/addr/data; observes req_ready, Write_* and pending_mask
//   slave  - the arbiter side, mirror image of master
interface regfile_wb_arbiter_if #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int NUM_REQ = 4
);
  logic                        wb_stall;
  logic [NUM_REQ-1:0]          req_valid;
  logic [NUM_REQ*ADDR_W-1:0]   req_addr;
  logic [NUM_REQ*DATA_W-1:0]   req_data;
  logic [NUM_REQ-1:0]          req_ready;

  logic                        Write_Enable_1;
  logic [ADDR_W-1:0]           Write_Addr_1;
  logic [DATA_W-1:0]           Write_Data_1;
  logic                        Write_Enable_2;
  logic [ADDR_W-1:0]           Write_Addr_2;
  logic [DATA_W-1:0]           Write_Data_2;
  logic [(1<<ADDR_W)-1:0]      pending_mask;

  modport master (
    output wb_stall, req_valid, req_addr, req_data,
    input  req_ready,
    input  Write_Enable_1, Write_Addr_1, Write_Data_1,
    input  Write_Enable_2, Write_Addr_2, Write_Data_2,
    input  pending_mask
  );

  modport slave (
    input  wb_stall, req_valid, req_addr, req_data,
    output req_ready,
    output Write_Enable_1, Write_Addr_1, Write_Data_1,
    output Write_Enable_2, Write_Addr_2, Write_Data_2,
    output pending_mask
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Purpose: round-robin arbiter sharing two register-file write ports among 4 writeback units.
// Latency: grant is combinational; the granted write appears on Write_* one cycle later.
// Backpressure: req_ready low holds requesters; wb_stall or reset suppresses all grants.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous active-low reset
//   bus   - slave modport: requester handshake in, register-file write ports and pending_mask out
module regfile_wb_arbiter #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int NUM_REQ = 4   // only 4 is supported
) (
  input logic                 clk,
  input logic                 reset,
  regfile_wb_arbiter_if.slave bus
);
  localparam int NREG = 1 << ADDR_W;

  logic [ADDR_W-1:0] r_addr [NUM_REQ];
  logic [DATA_W-1:0] r_data [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign r_addr[g] = bus.req_addr[g*ADDR_W +: ADDR_W];
    assign r_data[g] = bus.req_data[g*DATA_W +: DATA_W];
  end

  logic [1:0]         rr_ptr;
  logic               arb_en;
  logic               a_vld, b_vld;
  logic [1:0]         a_idx, b_idx, idx;
  logic [NUM_REQ-1:0] grant;

  // Grants are void while reset is held, so ready stays low then too.
  assign arb_en = reset & ~bus.wb_stall;

  // Scan from rr_ptr: first valid requester is A; the next valid one with a
  // different destination is B. Same-address requesters behind A wait, which
  // keeps the two ports from ever targeting one register in the same cycle.
  always_comb begin
    a_vld = 1'b0;
    b_vld = 1'b0;
    a_idx = '0;
    b_idx = '0;
    idx   = '0;
    grant = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = rr_ptr + 2'(k);
      if (arb_en && bus.req_valid[idx]) begin
        if (!a_vld) begin
          a_vld      = 1'b1;
          a_idx      = idx;
          grant[idx] = 1'b1;
        end else if (!b_vld && (r_addr[idx] != r_addr[a_idx])) begin
          b_vld      = 1'b1;
          b_idx      = idx;
          grant[idx] = 1'b1;
        end
      end
    end
  end

  assign bus.req_ready = grant;

  // Writes to r0 still consume a grant slot but never enable the port.
  logic            a_we, b_we;
  logic [NREG-1:0] mask_nxt;

  assign a_we = a_vld && (r_addr[a_idx] != '0);
  assign b_we = b_vld && (r_addr[b_idx] != '0);

  always_comb begin
    mask_nxt = '0;
    if (a_we) mask_nxt[r_addr[a_idx]] = 1'b1;
    if (b_we) mask_nxt[r_addr[b_idx]] = 1'b1;
  end

  logic              we1_q, we2_q;
  logic [ADDR_W-1:0] wa1_q, wa2_q;
  logic [DATA_W-1:0] wd1_q, wd2_q;
  logic [NREG-1:0]   mask_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      we1_q  <= 1'b0;
      wa1_q  <= '0;
      wd1_q  <= '0;
      we2_q  <= 1'b0;
      wa2_q  <= '0;
      wd2_q  <= '0;
      mask_q <= '0;
      rr_ptr <= '0;
    end else begin
      we1_q  <= a_we;
      we2_q  <= b_we;
      mask_q <= mask_nxt;
      // Idle ports keep their last address/data; only the enable drops.
      if (a_vld) begin
        wa1_q <= r_addr[a_idx];
        wd1_q <= r_data[a_idx];
      end
      if (b_vld) begin
        wa2_q <= r_addr[b_idx];
        wd2_q <= r_data[b_idx];
      end
      // B always lies after A in scan order, so it is the last one granted.
      if (a_vld) rr_ptr <= (b_vld ? b_idx : a_idx) + 2'd1;
    end
  end

  assign bus.Write_Enable_1 = we1_q;
  assign bus.Write_Addr_1   = wa1_q;
  assign bus.Write_Data_1   = wd1_q;
  assign bus.Write_Enable_2 = we2_q;
  assign bus.Write_Addr_2   = wa2_q;
  assign bus.Write_Data_2   = wd2_q;
  assign bus.pending_mask   = mask_q;
endmodule
